// File: rtl/data_bus_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// data_bus_ctrl_pkg
//
// Shared definitions for the CPU data-bus controller:
//   - bus_state_e   : read-tracking FSM encoding (IDLE / RD1 / RD2)
//   - target_e      : decoded destination of a bus request
//   - IO_*_OFS      : byte offsets of the I/O registers from IO_BASE
//   - STATUS_ERR_BIT: bit position of the sticky error flag in STATUS
//   - decode_addr() : address -> target classification
// -----------------------------------------------------------------------------
package data_bus_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // no read in flight
        ST_RD1  = 2'd1,   // read sitting in the lookup stage
        ST_RD2  = 2'd2    // read data being presented
    } bus_state_e;

    typedef enum logic [2:0] {
        TGT_RAM    = 3'd0,
        TGT_IO_OUT = 3'd1,
        TGT_CYCLE  = 3'd2,
        TGT_STATUS = 3'd3,
        TGT_BAD    = 3'd4   // misaligned or unmapped
    } target_e;

    localparam logic [31:0] IO_OUT_OFS    = 32'd0;
    localparam logic [31:0] IO_CYCLE_OFS  = 32'd4;
    localparam logic [31:0] IO_STATUS_OFS = 32'd8;

    localparam logic [4:0]  STATUS_ERR_BIT = 5'd0;

    // Classify a byte address. Alignment is checked first so a misaligned
    // address is an error even when it falls inside a mapped region. RAM is
    // tested before the I/O window, so RAM wins if the two ever overlap.
    function automatic target_e decode_addr(
        input logic [31:0] addr,
        input logic [32:0] ram_bytes,
        input logic [31:0] io_base
    );
        target_e tgt;
        tgt = TGT_BAD;
        if (addr[1:0] == 2'b00) begin
            if ({1'b0, addr} < ram_bytes) begin
                tgt = TGT_RAM;
            end else if (addr == io_base + IO_OUT_OFS) begin
                tgt = TGT_IO_OUT;
            end else if (addr == io_base + IO_CYCLE_OFS) begin
                tgt = TGT_CYCLE;
            end else if (addr == io_base + IO_STATUS_OFS) begin
                tgt = TGT_STATUS;
            end
        end
        return tgt;
    endfunction

endpackage

// File: rtl/data_bus_ctrl_data_ram.sv
// -----------------------------------------------------------------------------
// data_ram
//
// Single-port, synchronous-read, write-first 32-bit RAM.
//
// Ports:
//   clk    in   clock, all activity on the rising edge
//   en     in   access enable; rdata only changes on an enabled edge
//   we     in   1 = write wdata to addr (rdata shows the written word)
//   addr   in   word address
//   wdata  in   write data
//   rdata  out  registered read data
// -----------------------------------------------------------------------------
module data_ram #(
    parameter int unsigned WORDS = 1024,
    parameter int unsigned AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];

    // NOTE: the array has no reset branch on purpose: contents survive a bus
    // reset, and a resettable memory cannot map onto a RAM macro.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
                rdata     <= wdata;
            end else begin
                rdata     <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/data_bus_ctrl.sv
// -----------------------------------------------------------------------------
// data_bus_ctrl
//
// CPU data-bus controller: decodes each bus request to data RAM or a small
// I/O window, performs writes immediately and returns read data through a
// two-stage pipeline (accept -> lookup -> present), one request per cycle.
//
// Parameters:
//   RAM_WORDS  number of 32-bit RAM words (power of two, >= 2)
//   IO_BASE    byte address of the I/O window
//                +0 IO_OUT (r/w), +4 CYCLE (ro), +8 STATUS (ro, bit0 = ERR)
//
// Ports:
//   CLK             in   system clock, rising-edge active
//   RST             in   synchronous active-low reset
//   CS              in   request strobe, one request accepted per edge
//   WR_RD           in   1 = write, 0 = read
//   ADDR            in   byte address
//   Data_BUS_WRITE  in   write data
//   Data_BUS_READ   out  read data, holds while RD_VALID = 0
//   RD_VALID        out  one-cycle pulse, new read data two edges after accept
//   IO_OUT          out  general-purpose output register
//   ERR             out  sticky bus error (misaligned / unmapped access)
// -----------------------------------------------------------------------------
module data_bus_ctrl
    import data_bus_ctrl_pkg::*;
#(
    parameter int unsigned RAM_WORDS = 1024,
    parameter logic [31:0] IO_BASE   = 32'h0000_1000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CS,
    input  logic        WR_RD,
    input  logic [31:0] ADDR,
    input  logic [31:0] Data_BUS_WRITE,
    output logic [31:0] Data_BUS_READ,
    output logic        RD_VALID,
    output logic [31:0] IO_OUT,
    output logic        ERR
);

    localparam int unsigned AW        = $clog2(RAM_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) << 2;

    // ---------------------------------------------------------------- accept
    logic    accept;
    logic    rd_accept;
    logic    wr_accept;
    target_e req_tgt;

    // Requests seen while reset is asserted are dropped here, so nothing
    // downstream needs its own reset qualification.
    assign accept    = CS && RST;
    assign rd_accept = accept && !WR_RD;
    assign wr_accept = accept &&  WR_RD;
    assign req_tgt   = decode_addr(ADDR, RAM_BYTES, IO_BASE);

    // -------------------------------------------------------------------- RAM
    // The RAM is accessed on the accept edge itself: each request carries a
    // single address, so one port serves reads and writes without conflict,
    // and a read sees every write accepted on an earlier edge.
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_rdata;

    assign ram_en   = accept && (req_tgt == TGT_RAM);
    assign ram_we   = ram_en && WR_RD;
    assign ram_addr = ADDR[AW+1:2];

    data_ram #(
        .WORDS (RAM_WORDS),
        .AW    (AW)
    ) u_data_ram (
        .clk   (CLK),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (Data_BUS_WRITE),
        .rdata (ram_rdata)
    );

    // -------------------------------------------------------- read tracking
    bus_state_e state;

    // NOTE: every register in this design is assigned with <= so all flops
    // sample the same pre-edge values; a blocking = here would let later
    // statements see half-updated state and break the pipeline timing.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (rd_accept) state <= ST_RD1;
                ST_RD1:  state <= ST_RD2;
                ST_RD2:  state <= rd_accept ? ST_RD1 : ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------- pipeline data
    logic        s1_valid;      // read accepted on the previous edge
    target_e     s1_tgt;
    logic        lk_valid;      // lookup done, present on the next edge
    logic [31:0] lk_data;
    logic [31:0] cycle_cnt;
    logic [31:0] status_word;
    logic [31:0] lookup_value;
    logic        status_lookup;

    assign status_lookup = s1_valid && (s1_tgt == TGT_STATUS);

    // NOTE: always_comb outputs get a full default first so that no path
    // leaves them unassigned, which would otherwise infer a latch.
    always_comb begin
        status_word                 = '0;
        status_word[STATUS_ERR_BIT] = ERR;
    end

    // Value captured at the lookup edge. CYCLE and STATUS are the pre-edge
    // register values; misaligned/unmapped reads return zero.
    always_comb begin
        lookup_value = '0;
        case (s1_tgt)
            TGT_RAM:    lookup_value = ram_rdata;
            TGT_IO_OUT: lookup_value = IO_OUT;
            TGT_CYCLE:  lookup_value = cycle_cnt;
            TGT_STATUS: lookup_value = status_word;
            default:    lookup_value = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            s1_valid      <= 1'b0;
            s1_tgt        <= TGT_BAD;
            lk_valid      <= 1'b0;
            lk_data       <= '0;
            cycle_cnt     <= '0;
            Data_BUS_READ <= '0;
            RD_VALID      <= 1'b0;
            IO_OUT        <= '0;
            ERR           <= 1'b0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;

            // Accept stage.
            s1_valid <= rd_accept;
            s1_tgt   <= req_tgt;

            // Lookup stage. A read in s1 always leaves the tracker outside
            // IDLE, so the extra qualifier only keeps the two consistent.
            lk_valid <= s1_valid && (state != ST_IDLE);
            if (s1_valid) begin
                lk_data <= lookup_value;
            end

            // Present stage: data is only replaced when a read completes.
            RD_VALID <= lk_valid;
            if (lk_valid) begin
                Data_BUS_READ <= lk_data;
            end

            // Writes land on the accept edge; CYCLE and STATUS ignore them.
            if (wr_accept && (req_tgt == TGT_IO_OUT)) begin
                IO_OUT <= Data_BUS_WRITE;
            end

            // A new error on the same edge as a STATUS lookup takes priority
            // over the read-to-clear.
            if (accept && (req_tgt == TGT_BAD)) begin
                ERR <= 1'b1;
            end else if (status_lookup) begin
                ERR <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_data_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_data_bus_ctrl
//
// Directed scenarios followed by a randomized run, all checked against a
// transaction-level model: a word array for RAM, plain variables for the I/O
// registers and a queue of pending read results tagged with the edge at
// which they must appear.
// -----------------------------------------------------------------------------
module tb_data_bus_ctrl;

    localparam int unsigned RAM_WORDS = 1024;
    localparam logic [31:0] IO_BASE   = 32'h0000_1000;

    localparam int K_RAM  = 0;
    localparam int K_IO   = 1;
    localparam int K_CYC  = 2;
    localparam int K_STAT = 3;
    localparam int K_BAD  = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic        CS;
    logic        WR_RD;
    logic [31:0] ADDR;
    logic [31:0] Data_BUS_WRITE;
    logic [31:0] Data_BUS_READ;
    logic        RD_VALID;
    logic [31:0] IO_OUT;
    logic        ERR;

    always #5 CLK = ~CLK;

    data_bus_ctrl #(
        .RAM_WORDS (RAM_WORDS),
        .IO_BASE   (IO_BASE)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .CS             (CS),
        .WR_RD          (WR_RD),
        .ADDR           (ADDR),
        .Data_BUS_WRITE (Data_BUS_WRITE),
        .Data_BUS_READ  (Data_BUS_READ),
        .RD_VALID       (RD_VALID),
        .IO_OUT         (IO_OUT),
        .ERR            (ERR)
    );

    // ------------------------------------------------------------ model
    typedef struct {
        int          due;
        logic [31:0] val;
    } pend_t;

    pend_t       pend_q[$];
    logic [31:0] mem_m [RAM_WORDS];
    logic [31:0] io_m;
    logic [31:0] rd_m;
    logic        valid_m;
    logic        err_m;
    logic        clr_pend;
    int          edge_n   = 0;
    int          rst_edge = 0;
    int          checks   = 0;
    int          failures = 0;

    function automatic int kind_of(input logic [31:0] a);
        if (a % 4 != 0)           return K_BAD;
        if (a < RAM_WORDS * 4)    return K_RAM;
        if (a == IO_BASE)         return K_IO;
        if (a == IO_BASE + 32'd4) return K_CYC;
        if (a == IO_BASE + 32'd8) return K_STAT;
        return K_BAD;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock edge: drive at the falling edge, update the model at the
    // rising edge, compare all outputs shortly after it.
    task automatic step(input string tag, input logic rst_v, input logic cs_v,
                        input logic wr_v, input logic [31:0] a, input logic [31:0] d);
        pend_t       p;
        int          k;
        logic [31:0] v;
        @(negedge CLK);
        RST            = rst_v;
        CS             = cs_v;
        WR_RD          = wr_v;
        ADDR           = a;
        Data_BUS_WRITE = d;
        @(posedge CLK);
        edge_n++;
        if (!rst_v) begin
            pend_q.delete();
            io_m     = '0;
            err_m    = 1'b0;
            clr_pend = 1'b0;
            rd_m     = '0;
            rst_edge = edge_n;
            valid_m  = 1'b0;
        end else begin
            // A STATUS read accepted last edge clears ERR now; an error on
            // this edge is applied afterwards and therefore wins.
            if (clr_pend) err_m = 1'b0;
            clr_pend = 1'b0;
            if (cs_v) begin
                k = kind_of(a);
                if (k == K_BAD) err_m = 1'b1;
                if (wr_v) begin
                    if (k == K_RAM) mem_m[a / 4] = d;
                    if (k == K_IO)  io_m = d;
                end else begin
                    v = '0;
                    case (k)
                        K_RAM:  v = mem_m[a / 4];
                        K_IO:   v = io_m;
                        K_CYC:  v = 32'(edge_n - rst_edge);
                        K_STAT: begin v = {31'b0, err_m}; clr_pend = 1'b1; end
                        default: v = '0;
                    endcase
                    p.due = edge_n + 2;
                    p.val = v;
                    pend_q.push_back(p);
                end
            end
            valid_m = 1'b0;
            if (pend_q.size() > 0 && pend_q[0].due == edge_n) begin
                valid_m = 1'b1;
                rd_m    = pend_q[0].val;
                void'(pend_q.pop_front());
            end
        end
        #1;
        check({tag, " rd_valid"}, {31'b0, RD_VALID}, {31'b0, valid_m});
        check({tag, " rd_data"},  Data_BUS_READ, rd_m);
        check({tag, " io_out"},   IO_OUT, io_m);
        check({tag, " err"},      {31'b0, ERR}, {31'b0, err_m});
    endtask

    task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d);
        step(tag, 1'b1, 1'b1, 1'b1, a, d);
    endtask

    task automatic rd(input string tag, input logic [31:0] a);
        step(tag, 1'b1, 1'b1, 1'b0, a, 32'h0);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678);
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        logic [31:0] a;
        int          sel;

        RST = 1'b0; CS = 1'b0; WR_RD = 1'b0; ADDR = '0; Data_BUS_WRITE = '0;
        io_m = '0; rd_m = '0; valid_m = 1'b0; err_m = 1'b0; clr_pend = 1'b0;

        // Reset, with a write presented during reset that must be ignored.
        step("reset", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step("reset_req", 1'b0, 1'b1, 1'b1, IO_BASE, 32'hFFFF_FFFF);
        idle("post_reset", 1);

        // Preload the RAM words used below.
        for (int i = 0; i < 16; i++) wr("preload", 32'(i) * 32'd4, $urandom);
        wr("preload_last", 32'h0000_0FFC, $urandom);

        // Write then immediate read of the same word.
        wr("raw_wr", 32'h10, 32'hCAFE_F00D);
        rd("raw_rd", 32'h10);
        idle("raw_wait", 3);

        // Back-to-back reads of 1, 2, 3.
        wr("b2b_pre", 32'h0, 32'd1);
        wr("b2b_pre", 32'h4, 32'd2);
        wr("b2b_pre", 32'h8, 32'd3);
        rd("b2b_rd0", 32'h0);
        rd("b2b_rd1", 32'h4);
        rd("b2b_rd2", 32'h8);
        idle("b2b_wait", 3);

        // Misaligned write, RAM untouched, STATUS read-to-clear.
        wr("misalign_wr", 32'h2, 32'hFFFF_0000);
        rd("misalign_chk", 32'h0);
        rd("status_1", IO_BASE + 32'd8);
        rd("status_0", IO_BASE + 32'd8);
        idle("status_wait", 3);

        // IO_OUT write, ignored writes to CYCLE and STATUS, CYCLE read.
        wr("io_wr", IO_BASE, 32'h0000_005A);
        wr("cycle_wr", IO_BASE + 32'd4, 32'h0);
        wr("status_wr", IO_BASE + 32'd8, 32'hFFFF_FFFF);
        rd("cycle_rd", IO_BASE + 32'd4);
        rd("io_rd", IO_BASE);
        idle("io_wait", 3);

        // Unmapped read returns zero with a pulse and sets ERR.
        rd("unmapped_rd", 32'h0000_2000);
        idle("unmapped_wait", 3);

        // Error on the same edge as a STATUS lookup keeps ERR set.
        rd("status_race", IO_BASE + 32'd8);
        wr("status_race_err", IO_BASE + 32'd12, 32'h1);
        rd("status_race_chk", IO_BASE + 32'd8);
        idle("status_race_wait", 3);

        // Boundary addresses.
        rd("last_word", 32'h0000_0FFC);
        rd("io_edge_mis", IO_BASE + 32'd2);
        rd("io_edge_hi", IO_BASE + 32'd12);
        idle("edge_wait", 3);

        // In-flight read discarded by reset; CYCLE restarts.
        rd("flush_nz", 32'h10);
        idle("flush_nz_wait", 2);
        rd("flush_rd", 32'h4);
        step("flush_rst", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        rd("flush_cycle", IO_BASE + 32'd4);
        idle("flush_wait", 3);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 1500; n++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2, 3, 4: a = 32'($urandom_range(0, 15)) * 32'd4;
                5:             a = 32'h0000_0FFC;
                6:             a = IO_BASE + 32'($urandom_range(0, 2)) * 32'd4;
                7:             a = IO_BASE;
                8:             a = 32'($urandom_range(0, 15)) * 32'd4 + 32'($urandom_range(1, 3));
                default:       a = ($urandom_range(0, 1) == 0) ? IO_BASE + 32'd12 : ($urandom | 32'h8000_0000);
            endcase
            step("random", ($urandom_range(0, 99) >= 2), ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), a, $urandom);
        end
        idle("drain", 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
